nibble_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder built around a single cla_4bit instance. It feeds one
//   4-bit operand slice per clock into the CLA, LSB nibble first, and registers its

---
 rtl/nibble_serial_adder.sv | 175 +++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that walks one 4-bit slice per clock through a single CLA.
// Optional signed-overflow output is enabled by defining NSA_OVF_EN.

module cla_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is a flat generate/propagate term, so no carry ripples between bits.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       w_cla_sum;
    logic             w_cla_cout;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_run;
    logic             w_last;
    logic             w_accept;

    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_cnt == CW'(NIB - 1));
    assign w_accept = start && !w_run;

    cla_4bit u_cla (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_cin  (r_carry),
        .o_sum  (w_cla_sum),
        .o_cout (w_cla_cout)
    );

    // Each new slice enters at the MSB end; after NIB shifts the LSB slice sits at bit 0.
    if (NIB == 1) begin : g_one_nib
        assign w_acc_next = w_cla_sum;
    end else begin : g_multi_nib
        assign w_acc_next = {w_cla_sum, r_acc[WIDTH-1:4]};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // NOTE: the operand shift registers are reset too, so an aborted run leaves no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_carry <= w_cla_cout;
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_cla_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef NSA_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Overflow needs only the operand signs, because the final CLA slice gives the sum sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (w_last) begin
            r_ovf <= (r_a_msb == r_b_msb) && (w_cla_sum[3] != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector and random bench for nibble_serial_adder at WIDTH 4, 16 and 32.
// Define NSA_OVF_EN to also check the signed-overflow output.

module tb_nibble_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    logic        start_x;
    logic [31:0] ax;
    logic [31:0] bx;
    logic        cinx;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;
    logic        busy32;
    logic        done32;
    logic [31:0] sum32;
    logic        cout32;

`ifdef NSA_OVF_EN
    logic ovf16;
    logic ovf4;
    logic ovf32;
`endif

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef NSA_OVF_EN
        , .ovf(ovf16)
`endif
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_x), .a(ax[3:0]), .b(bx[3:0]), .cin(cinx),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef NSA_OVF_EN
        , .ovf(ovf4)
`endif
    );

    nibble_serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start_x), .a(ax), .b(bx), .cin(cinx),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
`ifdef NSA_OVF_EN
        , .ovf(ovf32)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts one 16-bit operation in cycle 0 and reports done cycle, busy cycles and overlap.
    task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                         output int lat, output int nbusy, output int both);
        @(negedge clk);
        a16 = ia;
        b16 = ib;
        cin16 = ic;
        start16 = 1'b1;
        lat = 0;
        nbusy = 0;
        both = 0;
        for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (busy16) nbusy++;
            if (busy16 && done16) both++;
            if (done16) lat = cyc;
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int nbusy;
        int both;
        int seen;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

        rst_n = 1'b0;
        start16 = 1'b0;
        a16 = '0;
        b16 = '0;
        cin16 = 1'b0;
        start_x = 1'b0;
        ax = '0;
        bx = '0;
        cinx = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy16), 64'd0);
        check("reset_done", 64'(done16), 64'd0);
        check("reset_sum", 64'(sum16), 64'd0);
        check("reset_cout", 64'(cout16), 64'd0);
`ifdef NSA_OVF_EN
        check("reset_ovf", 64'(ovf16), 64'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].cin, lat, nbusy, both);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
            check($sformatf("vec%0d_busy_cycles", i), 64'(nbusy), 64'd4);
            check($sformatf("vec%0d_busy_and_done", i), 64'(both), 64'd0);
            check($sformatf("vec%0d_sum", i), 64'(sum16), 64'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 64'(cout16), 64'(vecs[i].cout));
`ifdef NSA_OVF_EN
            check($sformatf("vec%0d_ovf", i), 64'(ovf16), 64'(vecs[i].ovf));
`endif
        end

        // Starts during RUN are ignored; a start in the DONE cycle is accepted back-to-back.
        @(negedge clk);
        a16 = 16'h1234;
        b16 = 16'h4321;
        cin16 = 1'b0;
        start16 = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start16 = (cyc == 2 || cyc == 3);
            if (cyc == 2) begin
                a16 = 16'hFFFF;
                b16 = 16'hFFFF;
                cin16 = 1'b1;
            end
            if (cyc == 4) check("seq4_busy_c4", 64'(busy16), 64'd1);
            if (cyc == 5) begin
                check("seq4_done_c5", 64'(done16), 64'd1);
                check("seq4_sum_c5", 64'(sum16), 64'h5555);
                check("seq4_cout_c5", 64'(cout16), 64'd0);
                a16 = 16'h7FFF;
                b16 = 16'h0001;
                cin16 = 1'b0;
                start16 = 1'b1;
            end
            if (cyc == 6) check("seq4_busy_c6", 64'(busy16), 64'd1);
            if (cyc == 9) begin
                check("seq4_done_c9", 64'(done16), 64'd0);
                check("seq4_sum_hold_c9", 64'(sum16), 64'h5555);
            end
            if (cyc == 10) begin
                check("seq4_done_c10", 64'(done16), 64'd1);
                check("seq4_sum_c10", 64'(sum16), 64'h8000);
            end
        end

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        a16 = 16'hFFFF;
        b16 = 16'h0000;
        cin16 = 1'b1;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("seq5_busy_async", 64'(busy16), 64'd0);
        check("seq5_done_async", 64'(done16), 64'd0);
        check("seq5_sum_async", 64'(sum16), 64'd0);
        check("seq5_cout_async", 64'(cout16), 64'd0);
        seen = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 2) rst_n = 1'b1;
            if (done16 || busy16) seen++;
        end
        check("seq5_no_activity_after_abort", 64'(seen), 64'd0);
        run16(16'h1234, 16'h4321, 1'b0, lat, nbusy, both);
        check("seq5_restart_latency", 64'(lat), 64'd5);
        check("seq5_restart_sum", 64'(sum16), 64'h5555);

        // Random operations on all three widths in parallel.
        for (int op = 0; op < 1000; op++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            logic [4:0]  e4;
            logic [16:0] e16;
            logic [32:0] e32;
            logic [4:0]  g4;
            logic [16:0] g16;
            logic [32:0] g32;
            int          l4;
            int          l16;
            int          l32;

            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1, 0));
            e4 = {1'b0, ra[3:0]} + {1'b0, rb[3:0]} + 5'(rc);
            e16 = {1'b0, ra[15:0]} + {1'b0, rb[15:0]} + 17'(rc);
            e32 = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            g4 = '0;
            g16 = '0;
            g32 = '0;
            l4 = 0;
            l16 = 0;
            l32 = 0;

            @(negedge clk);
            ax = ra;
            bx = rb;
            cinx = rc;
            a16 = ra[15:0];
            b16 = rb[15:0];
            cin16 = rc;
            start_x = 1'b1;
            start16 = 1'b1;
            for (int cyc = 1; cyc <= 14; cyc++) begin
                @(negedge clk);
                start_x = 1'b0;
                start16 = 1'b0;
                if (done4 && l4 == 0) begin
                    l4 = cyc;
                    g4 = {cout4, sum4};
                end
                if (done16 && l16 == 0) begin
                    l16 = cyc;
                    g16 = {cout16, sum16};
                end
                if (done32 && l32 == 0) begin
                    l32 = cyc;
                    g32 = {cout32, sum32};
                end
            end
            check($sformatf("rnd%0d_w4_latency", op), 64'(l4), 64'd2);
            check($sformatf("rnd%0d_w16_latency", op), 64'(l16), 64'd5);
            check($sformatf("rnd%0d_w32_latency", op), 64'(l32), 64'd9);
            check($sformatf("rnd%0d_w4_result", op), 64'(g4), 64'(e4));
            check($sformatf("rnd%0d_w16_result", op), 64'(g16), 64'(e16));
            check($sformatf("rnd%0d_w32_result", op), 64'(g32), 64'(e32));
`ifdef NSA_OVF_EN
            check($sformatf("rnd%0d_w16_ovf", op), 64'(ovf16),
                  64'((ra[15] == rb[15]) && (e16[15] != ra[15])));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
